uart_cfg_rx: RTL and testbench

Serial configuration receiver for the DRSSTC controller. It deserialises the 5-byte UART configuration packet on `uart_data` and presents the five 8-bit control parameters to the downstream stages: reference generator, phase predictor, OCD level DAC and interrupter. New values are committed atomically, only after a complete, error-free packet. Malformed or partial packets never disturb the parameters currently in use.

---
 rtl/uart_cfg_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_cfg_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_rx.sv
// ----------------------------------------------------------------------------
// uart_cfg_rx : UART receiver for the 5-byte DRSSTC configuration packet
// Rev 1.0     : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module uart_cfg_rx #(
  parameter int CLK_DIV      = 16,
  parameter int PAR_W        = 8,
  parameter int PAR_N        = 5,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_data,
  output logic [PAR_W-1:0] ref_gen,
  output logic [PAR_W-1:0] phase_shift,
  output logic [PAR_W-1:0] ocd_lvl,
  output logic [PAR_W-1:0] int_freq,
  output logic [PAR_W-1:0] int_pw,
  output logic             cfg_valid,
  output logic             frame_err
);

  localparam int CNT_W     = $clog2(CLK_DIV);
  localparam int BIT_W     = $clog2(PAR_W);
  localparam int IDX_W     = (PAR_N > 1) ? $clog2(PAR_N) : 1;
  localparam int TMO_LIMIT = TIMEOUT_BITS * CLK_DIV;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

  localparam logic [CNT_W-1:0] C_HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL_BIT = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(PAR_W - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(PAR_N - 1);
  localparam logic [TMO_W-1:0] C_TMO_END  = TMO_W'(TMO_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic                          sync1_q, sync1_d;
  logic                          rxs_q, rxs_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [BIT_W-1:0]              bit_idx_q, bit_idx_d;
  logic [PAR_W-1:0]              shreg_q, shreg_d;
  logic [IDX_W-1:0]              byte_idx_q, byte_idx_d;
  logic [TMO_W-1:0]              tmo_q, tmo_d;
  logic [PAR_N-1:0][PAR_W-1:0]   staging_q, staging_d;
  logic [PAR_N-1:0][PAR_W-1:0]   par_q, par_d;
  logic                          cfg_valid_q, cfg_valid_d;
  logic                          frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    sync1_d     = uart_data;
    rxs_d       = sync1_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    byte_idx_d  = byte_idx_q;
    tmo_d       = '0;
    staging_d   = staging_q;
    par_d       = par_q;
    cfg_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A start edge takes priority over a coincident timeout expiry
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = C_HALF_BIT;
        end else if (byte_idx_q != '0) begin
          if (tmo_q == C_TMO_END) begin
            byte_idx_d = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      S_START: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            state_d   = S_DATA;
            cnt_d     = C_FULL_BIT;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {shreg_q[PAR_W-2:0], rxs_q};
          cnt_d   = C_FULL_BIT;
          if (bit_idx_q == C_LAST_BIT) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            staging_d[byte_idx_q] = shreg_q;
            state_d               = S_IDLE;
            if (byte_idx_q == C_LAST_IDX) begin
              par_d       = staging_d;
              cfg_valid_d = 1'b1;
              byte_idx_d  = '0;
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            byte_idx_d  = '0;
            staging_d   = '0;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      byte_idx_q  <= '0;
      tmo_q       <= '0;
      staging_q   <= '0;
      par_q       <= '0;
      cfg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      byte_idx_q  <= byte_idx_d;
      tmo_q       <= tmo_d;
      staging_q   <= staging_d;
      par_q       <= par_d;
      cfg_valid_q <= cfg_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ref_gen     = par_q[0];
  assign phase_shift = par_q[1];
  assign ocd_lvl     = par_q[2];
  assign int_freq    = par_q[3];
  assign int_pw      = par_q[4];
  assign cfg_valid   = cfg_valid_q;
  assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cfg_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_cfg_rx : scoreboard bench for uart_cfg_rx
// Rev 1.0        : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_cfg_rx;

  localparam int CLK_DIV = 16;
  localparam int CLK_T   = 10;
  // Line edge (driven on a negedge) to the negedge where a pulse is visible:
  // 2 sync + 1 detect + CLK_DIV/2 + 9*CLK_DIV cycles
  localparam int LAT     = 3 + CLK_DIV / 2 + 9 * CLK_DIV;

  logic       clk;
  logic       rst;
  logic       uart_data;
  logic [7:0] ref_gen, phase_shift, ocd_lvl, int_freq, int_pw;
  logic       cfg_valid, frame_err;

  uart_cfg_rx #(
    .CLK_DIV      (CLK_DIV),
    .PAR_W        (8),
    .PAR_N        (5),
    .TIMEOUT_BITS (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_data   (uart_data),
    .ref_gen     (ref_gen),
    .phase_shift (phase_shift),
    .ocd_lvl     (ocd_lvl),
    .int_freq    (int_freq),
    .int_pw      (int_pw),
    .cfg_valid   (cfg_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #(CLK_T / 2) clk = ~clk;

  typedef struct {
    bit              is_cfg;
    logic [4:0][7:0] data;
    longint          t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0][7:0] pk(input logic [7:0] b0, b1, b2, b3, b4);
    return {b4, b3, b2, b1, b0};
  endfunction

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (cfg_valid || frame_err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got cfg_valid=%0b frame_err=%0b expected none at t=%0t",
                 cfg_valid, frame_err, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {62'd0, cfg_valid, frame_err}, mon_e.is_cfg ? 64'd2 : 64'd1);
        chk("pulse_time", $time, mon_e.t);
        if (mon_e.is_cfg) begin
          chk("ref_gen",     ref_gen,     mon_e.data[0]);
          chk("phase_shift", phase_shift, mon_e.data[1]);
          chk("ocd_lvl",     ocd_lvl,     mon_e.data[2]);
          chk("int_freq",    int_freq,    mon_e.data[3]);
          chk("int_pw",      int_pw,      mon_e.data[4]);
        end
      end
    end
  end

  // All stimulus tasks are entered and left on a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_data = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int k = 7; k >= 0; k--) begin
      uart_data = b[k];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_data = stop;
    repeat (CLK_DIV) @(negedge clk);
    uart_data = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    uart_data = 1'b1;
    repeat (n * CLK_DIV) @(negedge clk);
  endtask

  task automatic push_cfg(input logic [4:0][7:0] p);
    exp_t e;
    e.is_cfg = 1'b1;
    e.data   = p;
    e.t      = longint'($time) + LAT * CLK_T;
    sb.push_back(e);
  endtask

  task automatic push_ferr();
    exp_t e;
    e.is_cfg = 1'b0;
    e.data   = '0;
    e.t      = longint'($time) + LAT * CLK_T;
    sb.push_back(e);
  endtask

  task automatic send_packet(input logic [4:0][7:0] p);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) push_cfg(p);
      send_byte(p[i], 1'b1);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [4:0][7:0] p);
    chk({tag, "_ref_gen"},     ref_gen,     p[0]);
    chk({tag, "_phase_shift"}, phase_shift, p[1]);
    chk({tag, "_ocd_lvl"},     ocd_lvl,     p[2]);
    chk({tag, "_int_freq"},    int_freq,    p[3]);
    chk({tag, "_int_pw"},      int_pw,      p[4]);
  endtask

  initial begin
    rst       = 1'b1;
    uart_data = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs("reset", '0);
    chk("reset_cfg_valid", cfg_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    rst = 1'b0;
    idle_bits(2);

    // Nominal back-to-back packet
    send_packet(pk(8'hFE, 8'h3C, 8'hEA, 8'h50, 8'h80));
    idle_bits(2);

    // Bad stop bit on the third byte, then a clean packet
    send_byte(8'hFE, 1'b1);
    send_byte(8'h3C, 1'b1);
    push_ferr();
    send_byte(8'h5A, 1'b0);
    idle_bits(3);
    chk_outputs("after_ferr", pk(8'hFE, 8'h3C, 8'hEA, 8'h50, 8'h80));
    send_packet(pk(8'h11, 8'h22, 8'h33, 8'h44, 8'h55));
    idle_bits(2);

    // Short start glitch
    uart_data = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(2);
    send_packet(pk(8'h01, 8'h02, 8'h04, 8'h08, 8'h10));
    idle_bits(2);

    // Partial packet discarded after a long gap
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    send_byte(8'hC3, 1'b1);
    idle_bits(33);
    send_packet(pk(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5));
    idle_bits(2);

    // Partial packet kept across a gap shorter than the timeout
    send_byte(8'hB1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hB3, 1'b1);
    idle_bits(31);
    send_byte(8'hB4, 1'b1);
    push_cfg(pk(8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5));
    send_byte(8'hB5, 1'b1);
    idle_bits(2);

    // Reset during the third byte
    send_byte(8'hD1, 1'b1);
    send_byte(8'hD2, 1'b1);
    uart_data = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    uart_data = 1'b1;
    repeat (CLK_DIV) @(negedge clk);
    uart_data = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    rst       = 1'b1;
    uart_data = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_outputs("midrst", '0);
    chk("midrst_cfg_valid", cfg_valid, 0);
    idle_bits(3);
    send_packet(pk(8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5));
    idle_bits(4);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
